fetch_sequencer: RTL and testbench

- Sequences instruction fetch for the 72-bit processor.
- Owns the program counter and issues one request at a time to instruction memory.
- Holds each returned 72-bit instruction until the decoder accepts it.
- On a branch or jump from execute, redirects the PC and discards any in-flight fetch.
- Sits between instruction memory and decode, in place of a bare program-counter register in the processor top.

---
 rtl/proc_pkg.sv | 22 ++
 rtl/fetch_pc_reg.sv | 42 ++++
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions used by the fetch sequencer, decode and the
// processor top.
//   ADDR_W_DEF  : default instruction-memory word-address width
//   INSTR_W_DEF : default instruction width
//   RESET_PC    : program counter value after reset
//   fetch_state_e : fetch sequencer states
package proc_pkg;

   localparam int unsigned ADDR_W_DEF  = 16;
   localparam int unsigned INSTR_W_DEF = 72;

   localparam logic [ADDR_W_DEF-1:0] RESET_PC = '0;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DROP
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch sequencer.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, loads RESET_PC
//   redirect_i : load target_i (wins over inc_i)
//   target_i   : redirect target address
//   inc_i      : advance to the next word, wrapping at 2^ADDR_W
//   pc_o       : current program counter
module fetch_pc_reg #(
   parameter int unsigned        ADDR_W   = proc_pkg::ADDR_W_DEF,
   parameter logic [ADDR_W-1:0]  RESET_PC = proc_pkg::RESET_PC
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] target_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (redirect_i) begin
         pc_d = target_i;
      end else if (inc_i) begin
         pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one instruction-memory
// request at a time, holds the returned word until decode accepts it, and
// redirects on branch/jump, discarding any in-flight fetch.
//   clk, rst               : clock and synchronous active-high reset
//   halt                   : blocks starting new requests only
//   Branch_en, Jump_en     : redirect strobes, both use redirect_target
//   redirect_target        : new PC on redirect
//   imem_req, imem_addr    : one-cycle request and its word address
//   imem_ack, imem_rdata   : response strobe and instruction word
//   instr_valid, instr_out, instr_pc : held instruction towards decode
//   instr_ready            : decode accepts the held instruction
//   busy                   : sequencer not idle
module fetch_sequencer #(
   parameter int unsigned        ADDR_W   = proc_pkg::ADDR_W_DEF,
   parameter int unsigned        INSTR_W  = proc_pkg::INSTR_W_DEF,
   parameter logic [ADDR_W-1:0]  RESET_PC = proc_pkg::RESET_PC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               halt,
   input  logic               Branch_en,
   input  logic               Jump_en,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready,
   output logic               busy
);

   import proc_pkg::*;

   fetch_state_e       state_q;
   fetch_state_e       state_d;
   logic               redirect;
   logic               pc_inc;
   logic [ADDR_W-1:0]  pc;
   logic [INSTR_W-1:0] instr_q;
   logic [INSTR_W-1:0] instr_d;
   logic [ADDR_W-1:0]  ipc_q;
   logic [ADDR_W-1:0]  ipc_d;

   assign redirect = Branch_en | Jump_en;

   fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk_i      (clk),
      .rst_i      (rst),
      .redirect_i (redirect),
      .target_i   (redirect_target),
      .inc_i      (pc_inc),
      .pc_o       (pc)
   );

   always_comb begin
      state_d = state_q;
      pc_inc  = 1'b0;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      unique case (state_q)
         IDLE: begin
            if (!halt) state_d = REQ;
         end
         // The request leaves this cycle regardless; a redirect can only
         // turn its eventual response into a discard.
         REQ: begin
            state_d = redirect ? DROP : WAIT;
         end
         WAIT: begin
            if (imem_ack) begin
               if (redirect) begin
                  state_d = halt ? IDLE : REQ;
               end else begin
                  instr_d = imem_rdata;
                  ipc_d   = pc;
                  pc_inc  = 1'b1;
                  state_d = HOLD;
               end
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         // Redirect and accept both release the holding register; a
         // simultaneous accept still counts as a completed transfer.
         HOLD: begin
            if (redirect || instr_ready) state_d = halt ? IDLE : REQ;
         end
         DROP: begin
            if (imem_ack) state_d = halt ? IDLE : REQ;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         instr_q <= '0;
         ipc_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
      end
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = pc;
   assign instr_valid = (state_q == HOLD);
   assign instr_out   = instr_q;
   assign instr_pc    = ipc_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   localparam int unsigned AW = 16;
   localparam int unsigned IW = 72;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          halt = 1'b0;
   logic          Branch_en = 1'b0;
   logic          Jump_en = 1'b0;
   logic [AW-1:0] redirect_target = '0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [IW-1:0] imem_rdata = '0;
   logic          instr_valid;
   logic [IW-1:0] instr_out;
   logic [AW-1:0] instr_pc;
   logic          instr_ready = 1'b0;
   logic          busy;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .ADDR_W   (AW),
      .INSTR_W  (IW),
      .RESET_PC (16'h0000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .halt            (halt),
      .Branch_en       (Branch_en),
      .Jump_en         (Jump_en),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .instr_valid     (instr_valid),
      .instr_out       (instr_out),
      .instr_pc        (instr_pc),
      .instr_ready     (instr_ready),
      .busy            (busy)
   );

   int total = 0;
   int bad   = 0;

   // Transaction-level reference: what the fetcher has in flight and in hand.
   int unsigned   m_pc;
   bit            m_req_now;
   bit            m_out;
   bit            m_drop;
   bit            m_held;
   int unsigned   m_addr;
   int unsigned   m_hpc;
   logic [IW-1:0] m_data;

   // Memory responder and bookkeeping.
   int            mem_cnt;
   int            mem_lat;
   bit            data_fixed;
   int            cyc;
   bit            saw_req;
   int unsigned   last_req_addr;
   int            req_cyc[$];
   int unsigned   req_addr[$];

   task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IW-1:0] rnd_word();
      logic [95:0] w;
      w = {$urandom, $urandom, $urandom};
      return w[IW-1:0];
   endfunction

   task automatic step(input bit br, input bit jp, input logic [AW-1:0] tgt,
                       input bit rdy, input bit hlt);
      bit redir;
      bit nreq;
      cyc++;
      Branch_en       = br;
      Jump_en         = jp;
      redirect_target = tgt;
      instr_ready     = rdy;
      halt            = hlt;
      imem_ack        = 1'b0;
      imem_rdata      = rnd_word();
      if (mem_cnt > 0) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            imem_ack = 1'b1;
            if (data_fixed) imem_rdata = 72'hDE_ADDE_ADDE_ADDE_ADDE;
         end
      end
      @(negedge clk);
      chk("req", imem_req, m_req_now);
      if (m_req_now) chk("addr", imem_addr, m_pc);
      chk("valid", instr_valid, m_held);
      if (m_held) begin
         chk("instr", instr_out, m_data);
         chk("ipc", instr_pc, m_hpc);
      end
      chk("busy", busy, m_req_now | m_out | m_held);
      saw_req = (imem_req === 1'b1);
      if (saw_req) begin
         last_req_addr = imem_addr;
         req_cyc.push_back(cyc);
         req_addr.push_back(imem_addr);
         mem_cnt = (mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat;
      end
      @(posedge clk);
      redir = br | jp;
      nreq  = 1'b0;
      if (m_req_now) begin
         m_out  = 1'b1;
         m_drop = redir;
         m_addr = m_pc;
      end else if (m_out) begin
         if (imem_ack) begin
            m_out = 1'b0;
            if (!m_drop && !redir) begin
               m_held = 1'b1;
               m_data = imem_rdata;
               m_hpc  = m_addr;
               m_pc   = (m_addr + 1) % 65536;
            end else begin
               nreq = !hlt;
            end
         end else if (redir) begin
            m_drop = 1'b1;
         end
      end else if (m_held) begin
         if (redir || rdy) begin
            m_held = 1'b0;
            nreq   = !hlt;
         end
      end else begin
         nreq = !hlt;
      end
      if (redir) m_pc = tgt;
      m_req_now = nreq;
      #1;
   endtask

   task automatic run_until_req(input bit rdy, input bit hlt, input int limit, output int n);
      n = 0;
      do begin
         step(1'b0, 1'b0, '0, rdy, hlt);
         n++;
      end while (!saw_req && n < limit);
      chk("req_timeout", saw_req, 1'b1);
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      Branch_en       = 1'b0;
      Jump_en         = 1'b0;
      redirect_target = '0;
      instr_ready     = 1'b0;
      halt            = 1'b0;
      imem_ack        = 1'b0;
      imem_rdata      = '0;
      mem_cnt         = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr_out, '0);
      chk("rst_ipc", instr_pc, '0);
      chk("rst_busy", busy, 1'b0);
      m_pc      = 0;
      m_req_now = 1'b0;
      m_out     = 1'b0;
      m_drop    = 1'b0;
      m_held    = 1'b0;
      cyc       = 0;
      req_cyc.delete();
      req_addr.delete();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      mem_lat    = 1;
      data_fixed = 1'b0;

      // Streaming fetch with a one-cycle memory and decode always ready.
      do_reset();
      repeat (12) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("a_nreq", req_addr.size(), 4);
      for (int i = 0; i < 4 && i < req_addr.size(); i++) begin
         chk("a_addr", req_addr[i], i);
         chk("a_cycle", req_cyc[i], 2 + 3 * i);
      end

      // Decode backpressure for five cycles while holding word 3.
      repeat (5) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("b_noreq", req_addr.size(), 4);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      mem_lat = 4;
      run_until_req(1'b1, 1'b0, 8, n);
      chk("b_resume", n, 1);

      // Jump during WAIT; the late response must be discarded.
      data_fixed = 1'b1;
      step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0);
      mem_lat = 1;
      run_until_req(1'b1, 1'b0, 8, n);
      chk("c_addr", last_req_addr, 16'h0040);
      data_fixed = 1'b0;

      // Branch and jump together in HOLD with decode ready.
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 16'h0100, 1'b1, 1'b0);
      run_until_req(1'b1, 1'b0, 8, n);
      chk("d_lat", n, 1);
      chk("d_addr", last_req_addr, 16'h0100);

      // PC wrap from 0xFFFF.
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      run_until_req(1'b1, 1'b0, 8, n);
      chk("e_ffff", last_req_addr, 16'hFFFF);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      mem_lat = 3;
      run_until_req(1'b1, 1'b0, 8, n);
      chk("e_wrap", last_req_addr, 16'h0000);

      // Halt raised during WAIT: fetch completes, then the sequencer idles.
      repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("f_busy", busy, 1'b0);
      chk("f_noreq", imem_req, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("f_resume", saw_req, 1'b1);

      // Randomized traffic with a variable-latency memory and a mid-run reset.
      mem_lat = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         step($urandom_range(9) == 0, $urandom_range(11) == 0, 16'($urandom),
              $urandom_range(9) < 7, $urandom_range(9) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
